// File: rtl/bus_ram_p.sv
// ---------------------------------------------------------------------------
// bus_ram_p
//   Parametrised single-port synchronous RAM used as a slave on the simple bus.
//   It keeps the cen/wen request style and adds the following features:
//     - byte-lane write enables
//     - out-of-range detection
//     - a read-valid strobe with 1 or 2 cycles of latency
//     - a post-reset sequencer that clears every word to zero
//
// Ports
//   clk         rising-edge clock for all state
//   reset_n     asynchronous active-low reset
//   cen         request valid (chip enable)
//   wen         1 = write, 0 = read; only looked at when cen=1
//   be          byte-lane write enables; bit i covers din[8i+7:8i]
//   addr        word address
//   din         write data
//   dout        read data; forced to 0 whenever dout_valid=0
//   dout_valid  one-cycle strobe marking read data on dout
//   busy        high while the clear sequencer owns the array
//   err         one-cycle strobe for an accepted access with addr >= DEPTH
//
// Parameter legality
//   DATA_WIDTH must be a multiple of 8.
//   DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
//   READ_LATENCY must be 1 or 2.
// ---------------------------------------------------------------------------
module bus_ram_p #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int DEPTH          = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cen,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    // One extra bit so that DEPTH = 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    in_range;
    logic                    acc;
    logic                    wr_acc;
    logic                    rd_acc;

    // Read pipeline stage 1, which is loaded at the accepting edge.
    logic                    rd_v1;
    logic                    rd_e1;
    logic [DATA_WIDTH-1:0]   rd_d1;

    // Out-of-range write flag; it is always reported one cycle after acceptance.
    logic                    wr_err;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    assign in_range = {1'b0, addr} < DEPTH_W;
    assign acc      = cen & ~busy;
    assign wr_acc   = acc & wen;
    assign rd_acc   = acc & ~wen;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top means no path leaves state_d
    // unassigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt == LAST_WORD) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = RESET_STATE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        if (state_q == ST_CLEAR) busy = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Clear address counter
    // -----------------------------------------------------------------------
    // The counter is only meaningful in CLEAR. Because READY is terminal,
    // the wrap after the last word is harmless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt <= '0;
        end else if (busy) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset branch. Zeroing is done word by word by the
    // clear sequencer, so the array can still map onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline stage 1 and write error flag
    // -----------------------------------------------------------------------
    // The data register is zeroed whenever no in-range read is accepted. The
    // "dout=0 when not valid" rule therefore carries through any later stage
    // without extra masking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1  <= 1'b0;
            rd_e1  <= 1'b0;
            rd_d1  <= '0;
            wr_err <= 1'b0;
        end else begin
            rd_v1  <= rd_acc;
            rd_e1  <= rd_acc & ~in_range;
            rd_d1  <= (rd_acc && in_range) ? mem[addr] : '0;
            wr_err <= wr_acc & ~in_range;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage selected by READ_LATENCY
    // -----------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_v2;
            logic                  rd_e2;
            logic [DATA_WIDTH-1:0] rd_d2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_v2 <= 1'b0;
                    rd_e2 <= 1'b0;
                    rd_d2 <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    rd_e2 <= rd_e1;
                    rd_d2 <= rd_d1;
                end
            end

            assign dout       = rd_d2;
            assign dout_valid = rd_v2;
            // A read error (+2) and a write error (+1) can land in the same
            // cycle when an out-of-range write follows an out-of-range read.
            assign err        = rd_e2 | wr_err;
        end else begin : g_lat1
            assign dout       = rd_d1;
            assign dout_valid = rd_v1;
            assign err        = rd_e1 | wr_err;
        end
    endgenerate

endmodule

// File: tb/tb_bus_ram_p.sv
// ---------------------------------------------------------------------------
// tb_bus_ram_p
//   Directed bench for bus_ram_p. Three instances share one stimulus stream:
//     u_rl1  default 32x32 configuration with READ_LATENCY=1
//     u_rl2  32x32 configuration with READ_LATENCY=2
//     u_d20  DEPTH=20 configuration with READ_LATENCY=1, used for
//            out-of-range checks
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   that same point.
// ---------------------------------------------------------------------------
module tb_bus_ram_p;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cen;
    logic        wen;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;

    logic [31:0] dout_a, dout_b, dout_c;
    logic        dv_a, dv_b, dv_c;
    logic        busy_a, busy_b, busy_c;
    logic        err_a, err_b, err_c;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bus_ram_p #(.READ_LATENCY(1)) u_rl1 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be),
        .addr(addr), .din(din), .dout(dout_a), .dout_valid(dv_a),
        .busy(busy_a), .err(err_a)
    );

    bus_ram_p #(.READ_LATENCY(2)) u_rl2 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be),
        .addr(addr), .din(din), .dout(dout_b), .dout_valid(dv_b),
        .busy(busy_b), .err(err_b)
    );

    bus_ram_p #(.DEPTH(20), .READ_LATENCY(1)) u_d20 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be),
        .addr(addr), .din(din), .dout(dout_c), .dout_valid(dv_c),
        .busy(busy_c), .err(err_c)
    );

    // Unknown request controls while the RAM is accepting are a bench bug.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && busy_a === 1'b0) begin
            assert (!$isunknown({cen, wen}))
            else $error("stimulus error: X on cen/wen");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        cen = 1'b1; wen = 1'b1; addr = a; din = d; be = b;
        tick();
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        cen = 1'b1; wen = 1'b0; addr = a;
        tick();
        cen = 1'b0;
    endtask

    // Counts edges until busy_a drops, bounded to 100 edges.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_a && n < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n20;
        int vcount;

        reset_n = 1'b0; cen = 1'b0; wen = 1'b0; be = 4'h0; addr = '0; din = '0;
        tick(); tick();
        check("rst_busy",  {31'd0, busy_a}, 32'd1);
        check("rst_dv",    {31'd0, dv_a},   32'd0);
        check("rst_err",   {31'd0, err_a},  32'd0);
        check("rst_dout",  dout_a,          32'h0);

        // First bring-up, then preload word 5 through the bus.
        reset_n = 1'b1;
        wait_ready(n);
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        rd(5'd5);
        check("preload_rd", dout_a, 32'hDEADBEEF);

        // Reset pulse while idle; the outputs must react without a clock edge.
        reset_n = 1'b0;
        #1;
        check("pulse_busy", {31'd0, busy_b}, 32'd1);
        tick();
        reset_n = 1'b1;

        // Clear runs DEPTH edges. A write issued on the first edge is dropped.
        cen = 1'b1; wen = 1'b1; addr = 5'd3; din = 32'h12345678; be = 4'hF;
        n = 0; n20 = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                cen = 1'b0; wen = 1'b0;
                check("drop_dv",  {31'd0, dv_a},  32'd0);
                check("drop_err", {31'd0, err_a}, 32'd0);
            end
            if (!busy_c && n20 == 0) n20 = n;
        end while (busy_a && n < 100);
        check("clear_cycles_32", n,   32'd32);
        check("clear_cycles_20", n20, 32'd20);
        check("clear_busy_rl2",  {31'd0, busy_b}, 32'd0);

        // Word 5 was cleared. The latency-2 instance lags by one cycle.
        rd(5'd5);
        check("clr5_dv_a",   {31'd0, dv_a}, 32'd1);
        check("clr5_dout_a", dout_a,        32'h0);
        check("clr5_dv_b",   {31'd0, dv_b}, 32'd0);
        check("clr5_dout_c", dout_c,        32'h0);
        tick();
        check("clr5_dv_b2",   {31'd0, dv_b}, 32'd1);
        check("clr5_dout_b2", dout_b,        32'h0);
        check("clr5_dv_a_off", {31'd0, dv_a}, 32'd0);

        // The busy-time write to word 3 must not have happened.
        rd(5'd3);
        check("drop_rd_a", dout_a, 32'h0);
        tick();
        check("drop_rd_b", dout_b, 32'h0);

        // Byte lanes, followed by a read on the very next cycle.
        wr(5'd7, 32'hAABBCCDD, 4'hF);
        check("wr_no_dv", {31'd0, dv_a}, 32'd0);
        wr(5'd7, 32'h11223344, 4'b0101);
        rd(5'd7);
        check("lanes_a", dout_a, 32'hAA22CC44);
        tick();
        check("lanes_b", dout_b, 32'hAA22CC44);

        // Back-to-back reads on consecutive cycles.
        for (int i = 0; i < 4; i++) wr(5'(i), 32'(10 + i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            cen = 1'b1; wen = 1'b0; addr = 5'(i);
            tick();
            check("thr_dv_a",   {31'd0, dv_a}, 32'd1);
            check("thr_dout_a", dout_a,        32'(10 + i));
            if (i == 0) begin
                check("thr_dv_b0", {31'd0, dv_b}, 32'd0);
            end else begin
                check("thr_dv_b",   {31'd0, dv_b}, 32'd1);
                check("thr_dout_b", dout_b,        32'(9 + i));
            end
        end
        cen = 1'b0;
        tick();
        check("thr_end_dv_a", {31'd0, dv_a}, 32'd0);
        check("thr_last_dv_b", {31'd0, dv_b}, 32'd1);
        check("thr_last_b",    dout_b,        32'd13);
        tick();
        check("thr_end_dv_b", {31'd0, dv_b}, 32'd0);
        check("thr_end_dout_b", dout_b,      32'h0);

        // Out of range on the DEPTH=20 instance.
        wr(5'd5, 32'h55555555, 4'hF);
        wr(5'd25, 32'hCAFEF00D, 4'hF);
        check("oor_wr_err_c", {31'd0, err_c}, 32'd1);
        check("oor_wr_err_a", {31'd0, err_a}, 32'd0);
        check("oor_wr_dv_c",  {31'd0, dv_c},  32'd0);
        tick();
        check("oor_err_pulse", {31'd0, err_c}, 32'd0);
        rd(5'd5);
        check("oor_alias5", dout_c, 32'h55555555);
        check("oor_alias_err", {31'd0, err_c}, 32'd0);
        rd(5'd25);
        check("oor_rd_dv_c",   {31'd0, dv_c},  32'd1);
        check("oor_rd_dout_c", dout_c,         32'h0);
        check("oor_rd_err_c",  {31'd0, err_c}, 32'd1);
        check("inr_rd_dout_a", dout_a,         32'hCAFEF00D);
        check("inr_rd_err_a",  {31'd0, err_a}, 32'd0);
        tick();
        check("oor_rd_err_off", {31'd0, err_c}, 32'd0);
        check("inr_rd_err_b",   {31'd0, err_b}, 32'd0);
        check("inr_rd_b",       dout_b,         32'hCAFEF00D);

        // Reset while a latency-2 read is in flight.
        cen = 1'b1; wen = 1'b0; addr = 5'd7;
        tick();
        cen = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrd_busy_b", {31'd0, busy_b}, 32'd1);
        check("midrd_dv_b",   {31'd0, dv_b},   32'd0);
        check("midrd_dout_b", dout_b,          32'h0);
        check("midrd_dv_a",   {31'd0, dv_a},   32'd0);
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dv_b) vcount++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dv_b) vcount++;
        end

        // Reset in the middle of CLEAR restarts the sequence from word 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (dv_b) vcount++;
        end while (busy_a && n < 100);
        check("midrd_no_valid", vcount, 32'd0);
        check("midclr_cycles",  n,      32'd32);

        rd(5'd7);
        check("reclear_dv",   {31'd0, dv_a}, 32'd1);
        check("reclear_dout", dout_a,        32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
